// File: rtl/shift_concat.sv
// ---------------------------------------------------------------------------
// shift_concat
//
// Packs variable-width compressed chunks (1..OUT_W valid bits per beat,
// right-aligned in in_data) into contiguous OUT_W-bit words, MSB-first.
// The oldest bit of each word lands at out_data[OUT_W-1].
//
// Bits that do not yet fill a word are held in a left-justified residual
// register. A dump request flushes them as a zero-padded partial word.
// If the dump arrives with 64 or more bits available, the flush takes
// two cycles: a full word first, then the remainder from the FLUSH state.
//
// Ports:
//   clk        system clock; all logic is on the rising edge
//   rst        synchronous, active-low reset
//   stall      freezes all state while high
//   in_data    chunk; valid bits are in in_data[valid_bits-1:0]
//   valid_bits number of valid bits in in_data (legal 0..OUT_W)
//   in_valid   in_data/valid_bits are valid this cycle
//   dump       flush request (one-cycle pulse)
//   in_rdy     block can accept a chunk this cycle
//   out_data   packed word, oldest bit at the MSB
//   out_bits   valid bits in out_data (OUT_W for full words, fewer when flushing)
//   scon_done  one-cycle pulse: out_data/out_bits newly valid
//   dump_done  one-cycle pulse: flush complete, accumulator empty
//   err        sticky: valid_bits > OUT_W seen on an offered chunk
// ---------------------------------------------------------------------------
module shift_concat #(
  parameter int OUT_W = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [OUT_W-1:0] in_data,
  input  logic [CNT_W-1:0] valid_bits,
  input  logic             in_valid,
  input  logic             dump,
  output logic             in_rdy,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] out_bits,
  output logic             scon_done,
  output logic             dump_done,
  output logic             err
);

  localparam logic ACCUM = 1'b0;
  localparam logic FLUSH = 1'b1;

  localparam int W2   = 2 * OUT_W;
  localparam int SH_W = CNT_W + 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUT_W);

  logic             state_reg;
  logic [OUT_W-1:0] res_reg;   // left-justified residual, bits below cnt are zero
  logic [CNT_W-1:0] cnt_reg;

  logic             legal;
  logic             bad;
  logic             accept;
  logic [CNT_W-1:0] n_eff;
  logic [OUT_W-1:0] mask;
  logic [OUT_W-1:0] chunk;
  logic [SH_W-1:0]  sh;
  logic [W2-1:0]    merged;
  logic [CNT_W-1:0] total;
  logic             full;

  assign in_rdy = (state_reg == ACCUM);

  always_comb begin
    legal  = (valid_bits != '0) && (valid_bits <= FULL_CNT);
    bad    = (valid_bits > FULL_CNT);
    accept = in_valid & in_rdy & ~stall & legal;
    n_eff  = accept ? valid_bits : '0;
    // Keep only the valid low bits so that zero padding stays clean.
    mask   = legal ? ({OUT_W{1'b1}} >> (FULL_CNT - valid_bits)) : '0;
    chunk  = accept ? (in_data & mask) : '0;
    // Place the chunk in a double-width window so that its MSB sits directly
    // below the last residual bit: shift = 2*OUT_W - cnt - n.
    sh     = SH_W'(W2) - {1'b0, cnt_reg} - {1'b0, n_eff};
    merged = {res_reg, {OUT_W{1'b0}}} | ({{OUT_W{1'b0}}, chunk} << sh);
    // cnt <= OUT_W-1 and n <= OUT_W, so the sum fits in CNT_W bits.
    total  = cnt_reg + n_eff;
    full   = (total >= FULL_CNT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ACCUM;
      res_reg   <= '0;
      cnt_reg   <= '0;
      out_data  <= '0;
      out_bits  <= '0;
      scon_done <= 1'b0;
      dump_done <= 1'b0;
      err       <= 1'b0;
    end else if (stall) begin
      scon_done <= 1'b0;
      dump_done <= 1'b0;
    end else begin
      scon_done <= 1'b0;
      dump_done <= 1'b0;
      if (state_reg == ACCUM) begin
        if (in_valid && bad) begin
          err <= 1'b1;
        end
        if (full) begin
          out_data  <= merged[W2-1:OUT_W];
          out_bits  <= FULL_CNT;
          scon_done <= 1'b1;
          res_reg   <= merged[OUT_W-1:0];
          cnt_reg   <= total - FULL_CNT;
          // The remainder of a flush goes out on the next cycle.
          if (dump) begin
            state_reg <= FLUSH;
          end
        end else if (dump) begin
          if (total != '0) begin
            out_data  <= merged[W2-1:OUT_W];
            out_bits  <= total;
            scon_done <= 1'b1;
          end
          dump_done <= 1'b1;
          res_reg   <= '0;
          cnt_reg   <= '0;
        end else begin
          res_reg <= merged[W2-1:OUT_W];
          cnt_reg <= total;
        end
      end else begin
        // FLUSH: in_valid and dump are ignored here.
        if (cnt_reg != '0) begin
          out_data  <= res_reg;
          out_bits  <= cnt_reg;
          scon_done <= 1'b1;
        end
        dump_done <= 1'b1;
        res_reg   <= '0;
        cnt_reg   <= '0;
        state_reg <= ACCUM;
      end
    end
  end

endmodule

// File: tb/tb_shift_concat.sv
// ---------------------------------------------------------------------------
// tb_shift_concat
//
// Directed bench for shift_concat. Stimulus pushes the expected response
// into a queue; a monitor on the falling edge pops one entry whenever the
// DUT pulses scon_done or dump_done and compares it.
// ---------------------------------------------------------------------------
module tb_shift_concat;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [63:0] in_data;
  logic [6:0]  valid_bits;
  logic        in_valid;
  logic        dump;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [6:0]  out_bits;
  logic        scon_done;
  logic        dump_done;
  logic        err;

  typedef struct {
    logic [63:0] data;
    logic [6:0]  bits;
    logic        word;   // 1: scon_done expected with data; 0: dump_done only
    logic        dmp;    // dump_done expected together with the word
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic ok;
  int   checks   = 0;
  int   failures = 0;

  shift_concat #(.OUT_W(64), .CNT_W(7)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .in_data    (in_data),
    .valid_bits (valid_bits),
    .in_valid   (in_valid),
    .dump       (dump),
    .in_rdy     (in_rdy),
    .out_data   (out_data),
    .out_bits   (out_bits),
    .scon_done  (scon_done),
    .dump_done  (dump_done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (scon_done || dump_done) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse actual scon_done=%0b dump_done=%0b out_data=%h required no pulse",
                 scon_done, dump_done, out_data);
      end else begin
        e = sb.pop_front();
        if (e.word)
          ok = scon_done && (out_data == e.data) && (out_bits == e.bits) && (dump_done == e.dmp);
        else
          ok = !scon_done && dump_done;
        if (!ok)
          $display("FAIL scoreboard actual data=%h bits=%0d scon=%0b dump=%0b required data=%h bits=%0d scon=%0b dump=%0b",
                   out_data, out_bits, scon_done, dump_done, e.data, e.bits, e.word, e.word ? e.dmp : 1'b1);
        else
          $display("txn data=%h bits=%0d scon=%0b dump=%0b", out_data, out_bits, scon_done, dump_done);
        if (!ok) failures++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic exp_word(input logic [63:0] d, input int b, input logic dmp);
    exp_t x;
    x.data = d;
    x.bits = 7'(b);
    x.word = 1'b1;
    x.dmp  = dmp;
    sb.push_back(x);
  endtask

  task automatic exp_dump_only();
    exp_t x;
    x.data = '0;
    x.bits = '0;
    x.word = 1'b0;
    x.dmp  = 1'b1;
    sb.push_back(x);
  endtask

  task automatic send(input logic [63:0] d, input int n, input logic dmp);
    in_data    = d;
    valid_bits = 7'(n);
    in_valid   = 1'b1;
    dump       = dmp;
    tick();
    in_valid   = 1'b0;
    dump       = 1'b0;
  endtask

  task automatic pulse_dump();
    dump = 1'b1;
    tick();
    dump = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_out_data"},  out_data, 64'h0);
    chk({tag, "_out_bits"},  64'(out_bits), 64'h0);
    chk({tag, "_scon_done"}, 64'(scon_done), 64'h0);
    chk({tag, "_dump_done"}, 64'(dump_done), 64'h0);
    chk({tag, "_err"},       64'(err), 64'h0);
    chk({tag, "_in_rdy"},    64'(in_rdy), 64'h1);
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; in_data = '0; valid_bits = '0; in_valid = 1'b0; dump = 1'b0;
    tick();
    tick();
    chk_reset("reset");
    rst = 1'b1;
    tick();

    // Two 32-bit chunks make one word.
    send(64'hDEADBEEF, 32, 1'b0);
    exp_word(64'hDEADBEEF01234567, 64, 1'b0);
    send(64'h01234567, 32, 1'b0);

    // Two 40-bit chunks: word plus 16-bit residual, then flush it.
    send(64'hAA11112222, 40, 1'b0);
    exp_word(64'hAA11112222BB3333, 64, 1'b0);
    send(64'hBB33334444, 40, 1'b0);
    exp_word(64'h4444000000000000, 16, 1'b1);
    pulse_dump();

    // Residual 0x4444 plus a 60-bit chunk with same-cycle dump: two-cycle flush.
    send(64'h4444, 16, 1'b0);
    exp_word(64'h4444123456789ABC, 64, 1'b0);
    exp_word(64'hDEF0000000000000, 12, 1'b1);
    send(64'h0123456789ABCDEF, 60, 1'b1);
    chk("flush_in_rdy_low", 64'(in_rdy), 64'h0);
    send(64'hFF, 8, 1'b0);          // offered during FLUSH, must be ignored
    chk("flush_in_rdy_back", 64'(in_rdy), 64'h1);
    exp_dump_only();                // proves the FLUSH-cycle chunk was dropped
    pulse_dump();

    // Stall for 3 cycles with a 64-bit chunk offered; a dump during stall is lost.
    send(64'hA5, 8, 1'b0);
    stall = 1'b1; in_valid = 1'b1; in_data = 64'h0123456789ABCDEF; valid_bits = 7'd64;
    for (int i = 0; i < 3; i++) begin
      dump = (i == 1);
      tick();
      dump = 1'b0;
      chk("stall_scon_done", 64'(scon_done), 64'h0);
      chk("stall_out_data", out_data, 64'hDEF0000000000000);
    end
    exp_word(64'hA50123456789ABCD, 64, 1'b0);
    stall = 1'b0;
    tick();
    in_valid = 1'b0;
    exp_word(64'hEF00000000000000, 8, 1'b1);
    pulse_dump();

    // Exactly 64 bits from empty, then dump of an empty accumulator.
    exp_word(64'hFEDCBA9876543210, 64, 1'b0);
    send(64'hFEDCBA9876543210, 64, 1'b0);
    exp_dump_only();
    pulse_dump();

    // Illegal width sets sticky err and is dropped.
    send(64'hFFFFFFFFFFFFFFFF, 65, 1'b0);
    chk("err_set", 64'(err), 64'h1);
    send(64'h3C, 8, 1'b0);
    exp_word(64'h3C00000000000000, 8, 1'b1);
    pulse_dump();
    chk("err_sticky", 64'(err), 64'h1);

    // valid_bits==0 is a no-op.
    send(64'hFF, 0, 1'b0);
    exp_dump_only();
    pulse_dump();

    // Reset with 24 bits held.
    send(64'hABCDEF, 24, 1'b0);
    rst = 1'b0;
    tick();
    chk_reset("rst_cnt24");
    rst = 1'b1;
    exp_dump_only();
    pulse_dump();

    // Reset during FLUSH.
    send(64'h1111111111, 40, 1'b0);
    exp_word(64'h1111111111222222, 64, 1'b0);
    send(64'h2222222222, 40, 1'b1);
    chk("rst_flush_in_rdy_low", 64'(in_rdy), 64'h0);
    rst = 1'b0;
    tick();
    chk_reset("rst_flush");
    rst = 1'b1;
    exp_dump_only();
    pulse_dump();

    tick();
    tick();
    tick();
    chk("scoreboard_empty", 64'(sb.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_concat.md
Name: shift_concat

Overview:
- Sits between the compression module and the encryption/output stage.
- Packs variable-width compressed chunks (1..64 valid bits per beat) into contiguous 64-bit words, MSB-first.
- Pulses scon_done when a word is complete; the top-level control uses this pulse to drive out_valid.
- Supports a dump (flush) that emits a final zero-padded partial word.

Parameters:
- OUT_W, 64, width of the packed output word and max chunk width.
- CNT_W, 7, width of bit counters (valid_bits, out_bits).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-low reset (rst==0 at a rising edge resets the block)
- stall  input  1  freeze all state when high
- in_data  input  OUT_W  compressed chunk, valid bits right-aligned in in_data[valid_bits-1:0]
- valid_bits  input  CNT_W  number of valid bits in in_data (legal 0..64)
- in_valid  input  1  in_data/valid_bits valid this cycle
- dump  input  1  flush request (one-cycle pulse from control)
- in_rdy  output  1  block can accept a chunk this cycle
- out_data  output  OUT_W  packed word, oldest bit at bit 63
- out_bits  output  CNT_W  valid bits in out_data: 64 for full words, 1..63 for a flush word
- scon_done  output  1  one-cycle pulse: out_data/out_bits newly valid
- dump_done  output  1  one-cycle pulse: flush complete, accumulator empty
- err  output  1  sticky: illegal valid_bits (>64) seen

Behaviour:
- Reset (rst==0 at an edge):
  - out_data=0, out_bits=0, scon_done=0, dump_done=0, err=0, in_rdy=1.
  - Internal count cnt=0; state=ACCUM.
  - Reset takes priority over stall and everything else, including mid-flush.
- Internal storage: a residual register of up to 63 bits plus cnt (0..63), left-justified (oldest bit highest).
- Accept condition: in_valid & in_rdy & ~stall & (1 <= valid_bits <= 64).
  - valid_bits==0 with in_valid is a no-op.
  - valid_bits>64: err<=1, chunk dropped, cnt unchanged.
- On accept, with n=valid_bits and total=cnt+n:
  - Chunk bits are appended immediately after the existing residual bits.
  - total>=64: the oldest 64 bits go to out_data, out_bits=64, scon_done=1 in the following cycle, cnt<=total-64 (remaining bits kept left-justified).
  - total<64: cnt<=total, scon_done=0.
- Latency: output appears one clock after the accepting edge. scon_done is high for exactly one cycle per word. out_data holds its value until the next word.
- States:
  - ACCUM: in_rdy=1.
    - dump & ~stall: merge any same-cycle accepted chunk first, then act on the merged total.
    - total in 1..63: emit a zero-padded word (valid bits at top), out_bits=total, scon_done=1 and dump_done=1 together, cnt<=0, stay in ACCUM.
    - total==0: dump_done=1 only, no word.
    - total>=64: emit the full word now, cnt<=total-64, go to FLUSH.
  - FLUSH: in_rdy=0; in_valid ignored.
    - Next non-stalled cycle: emit the residual as a padded word, out_bits=cnt, scon_done=1, dump_done=1, cnt<=0, return to ACCUM.
    - If the residual is 0, only dump_done=1.
    - dump asserted during FLUSH is ignored.
- Stall:
  - No accept, no state change; cnt, residual and out_data hold.
  - scon_done and dump_done are driven 0 on a stalled edge.
  - A dump arriving during stall is lost; control re-issues it after the stall.
- err clears only on reset.

Test Plan:
- Two 32-bit chunks 0xDEADBEEF then 0x01234567 -> one cycle after the 2nd accept: scon_done=1, out_data=0xDEADBEEF01234567, out_bits=64, cnt=0.
- 40-bit 0xAA11112222 then 40-bit 0xBB33334444 -> out_data=0xAA11112222BB3333, out_bits=64, residual 0x4444 with cnt=16.
  - Then dump -> next cycle out_data=0x4444000000000000, out_bits=16, scon_done=1, dump_done=1.
- From residual 0x4444 (cnt=16), 60-bit 0x123456789ABCDEF with dump in the same cycle:
  - cycle+1: out_data=0x4444123456789ABC, out_bits=64, in_rdy=0.
  - cycle+2: out_data=0xDEF0000000000000, out_bits=12, scon_done=1, dump_done=1, in_rdy=1.
- stall=1 for 3 cycles with in_valid=1, valid_bits=64 -> scon_done=0 throughout, cnt and out_data unchanged. After release, the chunk is accepted once.
- valid_bits=65 with in_valid -> err=1 (sticky), no scon_done, cnt unchanged. A following legal chunk is accepted normally.
- rst=0 for one edge at cnt=24, and again during FLUSH -> all outputs at reset values, cnt=0, state ACCUM, in_rdy=1.
